// File: rtl/rs_gf_pkg.sv
// GF(2^8) helpers shared by the RS decoder: field constants, alpha power table,
// constant multiplication and the Chien search state encoding.
package rs_gf_pkg;

  localparam int GF_M = 8;
  localparam logic [GF_M:0] GF_POLY = 9'h11D;
  localparam int GF_ORDER = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chien_state_t;

  function automatic logic [GF_M-1:0] gf_xtime(input logic [GF_M-1:0] a);
    logic [GF_M-1:0] r;
    r = {a[GF_M-2:0], 1'b0};
    if (a[GF_M-1]) r = r ^ GF_POLY[GF_M-1:0];
    return r;
  endfunction

  function automatic logic [GF_ORDER-1:0][GF_M-1:0] gf_alpha_table();
    logic [GF_ORDER-1:0][GF_M-1:0] tbl;
    logic [GF_M-1:0] a;
    a = 8'd1;
    for (int i = 0; i < GF_ORDER; i++) begin
      tbl[8'(i)] = a;
      a = gf_xtime(a);
    end
    return tbl;
  endfunction

  localparam logic [GF_ORDER-1:0][GF_M-1:0] ALPHA_POW = gf_alpha_table();

  // value * alpha^power: each set input bit selects the column alpha^(power+i)
  function automatic logic [GF_M-1:0] gf_mul_const(input logic [GF_M-1:0] value, input int power);
    logic [GF_M-1:0] r;
    r = '0;
    for (int i = 0; i < GF_M; i++) begin
      if (value[i]) r = r ^ ALPHA_POW[8'((power + i) % GF_ORDER)];
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_gf_mult_const.sv
// Constant GF(2^8) multiplier: product = value * alpha^EXP as a fixed XOR network.
module rs_gf_mult_const
  import rs_gf_pkg::*;
#(
  parameter int EXP = 1
) (
  input  logic [GF_M-1:0] value,
  output logic [GF_M-1:0] product
);

  assign product = gf_mul_const(value, EXP);

endmodule

// File: rtl/rs_chien_search.sv
// Chien search: evaluates Lambda(alpha^-p) for p = N-1 down to 0, flags roots,
// counts them against the locator degree and emits the odd-term sum for Forney.
module rs_chien_search
  import rs_gf_pkg::*;
#(
  parameter int T = 8,
  parameter int N = 255,
  parameter int M = GF_M
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               enable,
  input  logic               start,
  input  logic [(T+1)*M-1:0] lambda_in,
  input  logic [3:0]         degree_in,
  output logic               busy,
  output logic               err_valid,
  output logic               err_flag,
  output logic [7:0]         err_pos,
  output logic [M-1:0]       odd_sum,
  output logic               done,
  output logic [7:0]         root_count,
  output logic               fail
);

  localparam logic [7:0] LAST_POS = 8'(N - 1);
  // 256-N modulo the field order: shortened codes start at alpha^-(N-1)
  localparam int LOAD_STEP = (GF_ORDER + 1 - N) % GF_ORDER;

  chien_state_t state, state_next;
  logic         load_en, step_en, last_pos;

  logic [M-1:0] lam        [T+1];
  logic [M-1:0] lam_scaled [T+1];
  logic [M-1:0] coef_p0    [T+1];
  logic [M-1:0] coef_next  [T+1];
  logic [M-1:0] sum_p0, odd_p0;
  logic [7:0]   pos_p0;
  logic [3:0]   degree_p0;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  for (genvar j = 0; j <= T; j++) begin : g_load
    assign lam[j] = lambda_in[j*M +: M];
    rs_gf_mult_const #(.EXP((j * LOAD_STEP) % GF_ORDER)) u_load (
      .value  (lam[j]),
      .product(lam_scaled[j])
    );
  end

  assign coef_next[0] = coef_p0[0];
  for (genvar j = 1; j <= T; j++) begin : g_step
    rs_gf_mult_const #(.EXP(j % GF_ORDER)) u_step (
      .value  (coef_p0[j]),
      .product(coef_next[j])
    );
  end

  always_comb begin
    sum_p0 = '0;
    odd_p0 = '0;
    for (int j = 0; j <= T; j++) begin
      sum_p0 = sum_p0 ^ coef_p0[j];
      if (j % 2 == 1) odd_p0 = odd_p0 ^ coef_p0[j];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (load_en) state_next = ST_RUN;
      ST_RUN:  if (last_pos) state_next = ST_DONE;
      ST_DONE: begin
        if (load_en)     state_next = ST_RUN;
        else if (enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_RUN);
    load_en  = enable && start && (state != ST_RUN);
    step_en  = enable && (state == ST_RUN);
    last_pos = step_en && (pos_p0 == 8'd0);
  end

  // p0 -> p1: coefficient step and registered position outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int j = 0; j <= T; j++) coef_p0[j] <= '0;
      pos_p0     <= '0;
      degree_p0  <= '0;
      err_valid  <= 1'b0;
      err_flag   <= 1'b0;
      err_pos    <= '0;
      odd_sum    <= '0;
      done       <= 1'b0;
      root_count <= '0;
      fail       <= 1'b0;
    end else begin
      err_valid <= step_en;
      done      <= enable && (state == ST_DONE);
      if (load_en) begin
        for (int j = 0; j <= T; j++) coef_p0[j] <= lam_scaled[j];
        pos_p0     <= LAST_POS;
        degree_p0  <= degree_in;
        root_count <= '0;
        fail       <= 1'b0;
      end else if (step_en) begin
        for (int j = 0; j <= T; j++) coef_p0[j] <= coef_next[j];
        pos_p0   <= pos_p0 - 8'd1;
        err_flag <= (sum_p0 == '0);
        err_pos  <= pos_p0;
        odd_sum  <= odd_p0;
        if (sum_p0 == '0) root_count <= sat_inc(root_count);
      end else if (enable && (state == ST_DONE)) begin
        fail <= (root_count != {4'b0, degree_p0});
      end
    end
  end

endmodule

// File: tb/tb_rs_chien_search.sv
// Directed bench for rs_chien_search: stimulus pushes expected per-position and
// end-of-codeword results into queues, a negedge monitor pops and compares.
module tb_rs_chien_search;

  localparam int T = 8;
  localparam int N = 255;
  localparam int M = 8;

  logic               CLK = 1'b0;
  logic               RESET, enable, start;
  logic [(T+1)*M-1:0] lambda_in;
  logic [3:0]         degree_in;
  logic               busy, err_valid, err_flag, done, fail;
  logic [7:0]         err_pos, root_count;
  logic [M-1:0]       odd_sum;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    bit         flag;
    logic [7:0] pos;
    logic [7:0] odd;
    bit         chk_odd;
  } err_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] count;
    bit         fl;
  } done_exp_t;

  err_exp_t  err_q[$];
  done_exp_t done_q[$];

  rs_chien_search #(.T(T), .N(N), .M(M)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .enable    (enable),
    .start     (start),
    .lambda_in (lambda_in),
    .degree_in (degree_in),
    .busy      (busy),
    .err_valid (err_valid),
    .err_flag  (err_flag),
    .err_pos   (err_pos),
    .odd_sum   (odd_sum),
    .done      (done),
    .root_count(root_count),
    .fail      (fail)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [(T+1)*M-1:0] mk(input logic [7:0] l0, input logic [7:0] l1,
                                            input logic [7:0] l2);
    logic [(T+1)*M-1:0] v;
    v = '0;
    v[7:0]   = l0;
    v[15:8]  = l1;
    v[23:16] = l2;
    return v;
  endfunction

  always @(negedge CLK) begin : monitor
    err_exp_t  e;
    done_exp_t d;
    if (err_valid === 1'b1) begin
      if (err_q.size() == 0) begin
        check("err_valid_unexpected", err_valid, 0);
      end else begin
        e = err_q.pop_front();
        check("err_cycle", cyc, e.cyc);
        check("err_flag", err_flag, e.flag);
        check("err_pos", err_pos, e.pos);
        if (e.chk_odd) check("odd_sum", odd_sum, e.odd);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", done, 0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("root_count", root_count, d.count);
        check("fail", fail, d.fl);
      end
    end
  end

  task automatic expect_run(input int c0, input int n_out, input int stall_at, input int stall_len,
                            input bit all_flag, input int nf,
                            input logic [7:0] fp0, input logic [7:0] fo0,
                            input logic [7:0] fp1, input logic [7:0] fo1,
                            input bit odd_zero, input bit with_done,
                            input logic [7:0] count, input bit fl);
    err_exp_t  e;
    done_exp_t d;
    bit        hit0, hit1;
    for (int k = 0; k < n_out; k++) begin
      e.pos     = 8'(N - 1 - k);
      e.cyc     = c0 + 1 + k + ((k >= stall_at) ? stall_len : 0);
      hit0      = (nf > 0) && (e.pos == fp0);
      hit1      = (nf > 1) && (e.pos == fp1);
      e.flag    = all_flag || hit0 || hit1;
      e.chk_odd = odd_zero || hit0 || hit1;
      e.odd     = odd_zero ? 8'h00 : (hit0 ? fo0 : fo1);
      err_q.push_back(e);
    end
    if (with_done) begin
      d.cyc   = c0 + N + 1 + stall_len;
      d.count = count;
      d.fl    = fl;
      done_q.push_back(d);
    end
  endtask

  task automatic do_start(input logic [(T+1)*M-1:0] lam, input logic [3:0] deg, output int c0);
    lambda_in = lam;
    degree_in = deg;
    start     = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) check("done_timeout", done, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    bit found;
    RESET     = 1'b1;
    enable    = 1'b1;
    start     = 1'b0;
    lambda_in = '0;
    degree_in = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_pos", err_pos, 0);
    check("rst_odd_sum", odd_sum, 0);
    check("rst_done", done, 0);
    check("rst_root_count", root_count, 0);
    check("rst_fail", fail, 0);
    @(posedge CLK);
    #1;

    // constant locator: no roots
    do_start(mk(8'h01, 8'h00, 8'h00), 4'd0, c0);
    expect_run(c0, N, N, 0, 1'b0, 0, 8'd0, 8'h00, 8'd0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0);
    check("busy_run", busy, 1);
    wait_done(N + 20);

    // single root at position 10
    do_start(mk(8'h01, 8'h74, 8'h00), 4'd1, c0);
    expect_run(c0, N, N, 0, 1'b0, 1, 8'd10, 8'h01, 8'd0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0);
    wait_done(N + 20);

    // roots at 254 and 0
    do_start(mk(8'h01, 8'h8F, 8'h8E), 4'd2, c0);
    expect_run(c0, N, N, 0, 1'b0, 2, 8'd254, 8'h03, 8'd0, 8'h8F, 1'b0, 1'b1, 8'd2, 1'b0);
    wait_done(N + 20);

    // degree mismatch, plus a start pulse during RUN that must be ignored
    do_start(mk(8'h01, 8'h74, 8'h00), 4'd2, c0);
    expect_run(c0, N, N, 0, 1'b0, 1, 8'd10, 8'h01, 8'd0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b1);
    repeat (50) @(posedge CLK);
    #1;
    start     = 1'b1;
    lambda_in = '0;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check("busy_after_run_start", busy, 1);
    wait_done(N + 20);

    // 5-cycle stall after 20 positions
    do_start(mk(8'h01, 8'h74, 8'h00), 4'd1, c0);
    expect_run(c0, N, 20, 5, 1'b0, 1, 8'd10, 8'h01, 8'd0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0);
    repeat (20) @(posedge CLK);
    #1;
    enable = 1'b0;
    repeat (5) begin
      @(posedge CLK);
      #1;
      check("stall_err_valid", err_valid, 0);
      check("stall_err_pos", err_pos, 235);
      check("stall_busy", busy, 1);
    end
    enable = 1'b1;
    wait_done(N + 30);

    // all-zero locator: every position is a root
    do_start(mk(8'h00, 8'h00, 8'h00), 4'd3, c0);
    expect_run(c0, N, N, 0, 1'b1, 0, 8'd0, 8'h00, 8'd0, 8'h00, 1'b1, 1'b1, 8'd255, 1'b1);
    wait_done(N + 20);

    // reset once position 100 has been output
    do_start(mk(8'h01, 8'h74, 8'h00), 4'd1, c0);
    expect_run(c0, 155, N, 0, 1'b0, 1, 8'd10, 8'h01, 8'd0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge CLK);
      #1;
      if (err_valid === 1'b1 && err_pos == 8'd100) found = 1'b1;
    end
    if (!found) check("reset_target_timeout", err_pos, 100);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_err_valid", err_valid, 0);
    check("midrst_root_count", root_count, 0);
    check("midrst_err_pos", err_pos, 0);
    check("midrst_done", done, 0);
    repeat (5) @(posedge CLK);
    #1;

    do_start(mk(8'h01, 8'h74, 8'h00), 4'd1, c0);
    expect_run(c0, N, N, 0, 1'b0, 1, 8'd10, 8'h01, 8'd0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0);
    wait_done(N + 20);

    repeat (5) @(posedge CLK);
    #1;
    check("err_queue_empty", err_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
